fu_cdb_arbiter: RTL

- Collects registered results from the functional units (alu, mlu, brcond-derived branch results) and broadcasts them on the 2-wide common data bus (CDB) to the RS and ROB.
- Each FU has a small result FIFO, because the FUs have no back-pressure.
- Up to two results are granted per cycle under round-robin priority.
- A per-FU stall goes back to issue so that no FIFO overflows.

---
 rtl/fu_cdb_arbiter_if.sv | 28 ++
 rtl/fu_cdb_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fu_cdb_arbiter_if.sv
// FU-result / CDB bundle for fu_cdb_arbiter.
//   fu_valid/fu_result/fu_tag : per-FU registered results (slot i = [i*W +: W])
//   fu_stall                  : per-FU issue stall back to issue
//   cdb_valid/cdb_value/cdb_tag : 2-wide common data bus (port p = [p*W +: W])
// master = FU/issue side, slave = arbiter.
interface fu_cdb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*XLEN-1:0]  fu_result;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU-1:0]       fu_stall;
  logic [1:0]              cdb_valid;
  logic [2*XLEN-1:0]       cdb_value;
  logic [2*TAG_W-1:0]      cdb_tag;

  modport master (
    output fu_valid, fu_result, fu_tag,
    input  fu_stall, cdb_valid, cdb_value, cdb_tag
  );

  modport slave (
    input  fu_valid, fu_result, fu_tag,
    output fu_stall, cdb_valid, cdb_value, cdb_tag
  );
endinterface

// File: rtl/fu_cdb_arbiter.sv
// fu_cdb_arbiter: buffers FU results in per-FU FIFOs and broadcasts up to two
// per cycle on the 2-wide CDB under round-robin priority.
//   clock, reset  : clock, synchronous active-high reset
//   squash        : flush all buffered/incoming results, rr pointer back to 0
//   bus (slave)   : FU result inputs, per-FU stall, registered CDB outputs
//   overflow_err  : sticky, set when a push hits a full FIFO that is not popping

// Per-FU result FIFO. Pointers wrap naturally because DEPTH is a power of 2.
module fu_cdb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         stall_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_STALL = (AW+1)'(DEPTH-1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, do_push, do_pop;

  assign full    = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // a full FIFO still accepts when it is popping this same cycle
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;
  assign head_o  = mem_q[rd_q];
  // one entry of headroom for the result already sitting in the FU register
  assign stall_o = (cnt_q >= CNT_STALL);

  always_comb begin
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

module fu_cdb_arbiter #(
  parameter int XLEN   = 32,
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  fu_cdb_arbiter_if.slave bus,
  output logic            overflow_err
);
  localparam int EW = TAG_W + XLEN;
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0][EW-1:0] head;
  logic [NUM_FU-1:0]         empty, pop, ovf, stall;
  logic [IW-1:0]             rr_q, rr_d, g0, g1;
  logic                      g0_vld, g1_vld;
  logic [1:0]                cdb_valid_q, cdb_valid_d;
  logic [1:0][EW-1:0]        cdb_q, cdb_d;
  logic                      overflow_q, overflow_d;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (32'(v) == NUM_FU - 1) ? '0 : v + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    fu_cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush_i (squash),
      .push_i  (bus.fu_valid[i]),
      .pop_i   (pop[i]),
      .din_i   ({bus.fu_tag[i*TAG_W +: TAG_W], bus.fu_result[i*XLEN +: XLEN]}),
      .head_o  (head[i]),
      .empty_o (empty[i]),
      .stall_o (stall[i]),
      .ovf_o   (ovf[i])
    );
    assign pop[i] = (g0_vld && g0 == IW'(i)) || (g1_vld && g1 == IW'(i));
  end

  // Round-robin scan from rr_q: first non-empty -> port 0, next -> port 1.
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0     = '0;
    g1     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      logic [IW-1:0] idx;
      idx = IW'((32'(rr_q) + 32'(k)) % NUM_FU);
      if (!empty[idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = idx;
        end
      end
    end
  end

  always_comb begin
    cdb_valid_d = {g1_vld, g0_vld};
    cdb_d       = '0;
    if (g0_vld) cdb_d[0] = head[g0];
    if (g1_vld) cdb_d[1] = head[g1];
    rr_d = rr_q;
    if (g1_vld)      rr_d = inc_wrap(g1);
    else if (g0_vld) rr_d = inc_wrap(g0);
    overflow_d = overflow_q | (|ovf);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q        <= '0;
      cdb_valid_q <= '0;
      cdb_q       <= '0;
      overflow_q  <= 1'b0;
    end else if (squash) begin
      // incoming results are dropped, so no overflow can be raised here
      rr_q        <= '0;
      cdb_valid_q <= '0;
      cdb_q       <= '0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.fu_stall  = stall;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_value = {cdb_q[1][XLEN-1:0], cdb_q[0][XLEN-1:0]};
  assign bus.cdb_tag   = {cdb_q[1][EW-1:XLEN], cdb_q[0][EW-1:XLEN]};
  assign overflow_err  = overflow_q;
endmodule
